display_raster_out: RTL

//   Raster scan-out stage directly downstream of DataPath. Walks the frame buffer in raster order,

---
 rtl/display_raster_out.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/display_raster_out.sv
// display_raster_out: walks the frame buffer in raster order and emits a timed pixel stream with sync.
// Latency: pix_valid/pix_data follow frame_rd_en by one cycle; frames run back-to-back while enable is high.
// No backpressure: the sink takes one pixel per active cycle; timing words are sampled at frame start only.
module display_raster_out #(
  parameter int DW = 8,
  parameter int AW = 16,
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [TW-1:0] HBOut_PD,
  input  logic [TW-1:0] VBOut_PD,
  input  logic [TW-1:0] AIPOut_PD,
  input  logic [TW-1:0] AILOut_PD,
  output logic          frame_rd_en,
  output logic [AW-1:0] frame_rd_addr,
  input  logic [DW-1:0] frame_rd_data,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          hsync,
  output logic          vsync,
  output logic [TW-1:0] line_cnt,
  output logic          frame_done,
  output logic          cfg_err
);
  // Product is wide enough for any TW-bit operands, so the size limit can never alias.
  localparam int PW = (2 * TW > AW + 1) ? 2 * TW : AW + 1;

  typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] hb_q, vb_q, aip_q, ail_q;
  logic [TW-1:0] hb_nxt, vb_nxt, aip_nxt, ail_nxt;
  logic [TW-1:0] col_q, col_nxt, row_q, row_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic          vseg_q, vseg_nxt;
  logic          lstart_q, lstart_nxt;
  logic          err_q, err_nxt;
  logic          pv_q, done_q;
  logic          last_rd;
  logic          go_frame, go_vb, go_act;
  logic [PW-1:0] area;
  logic          cfg_ok;

  assign area    = PW'(AIPOut_PD) * PW'(AILOut_PD);
  assign cfg_ok  = (AIPOut_PD != '0) && (AILOut_PD != '0) && (area <= (PW'(1) << AW));
  assign last_rd = (state == ACTIVE) && (col_q == aip_q - 1'b1) && (row_q == ail_q - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hb_q     <= '0;
      vb_q     <= '0;
      aip_q    <= '0;
      ail_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      vseg_q   <= 1'b0;
      lstart_q <= 1'b0;
      err_q    <= 1'b0;
      pv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hb_q     <= hb_nxt;
      vb_q     <= vb_nxt;
      aip_q    <= aip_nxt;
      ail_q    <= ail_nxt;
      col_q    <= col_nxt;
      row_q    <= row_nxt;
      addr_q   <= addr_nxt;
      vseg_q   <= vseg_nxt;
      lstart_q <= lstart_nxt;
      err_q    <= err_nxt;
      pv_q     <= (state == ACTIVE);
      done_q   <= last_rd;
    end
  end

  always_comb begin
    state_nxt  = state;
    hb_nxt     = hb_q;
    vb_nxt     = vb_q;
    aip_nxt    = aip_q;
    ail_nxt    = ail_q;
    col_nxt    = col_q;
    row_nxt    = row_q;
    addr_nxt   = addr_q;
    vseg_nxt   = vseg_q;
    lstart_nxt = 1'b0;
    err_nxt    = err_q;
    go_frame   = 1'b0;
    go_vb      = 1'b0;
    go_act     = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          if (cfg_ok) go_frame = 1'b1;
          else        err_nxt  = 1'b1;
        end
      end
      // vseg_q selects the HB part (0) or the blanked AIP part (1) of a VB line.
      VBLANK: begin
        col_nxt = col_q + 1'b1;
        if (!vseg_q && col_q == hb_q - 1'b1) begin
          vseg_nxt = 1'b1;
          col_nxt  = '0;
        end else if (vseg_q && col_q == aip_q - 1'b1) begin
          if (row_q == vb_q - 1'b1) begin
            row_nxt = '0;
            go_act  = 1'b1;
          end else begin
            row_nxt = row_q + 1'b1;
            go_vb   = 1'b1;
          end
        end
      end
      HBLANK: begin
        col_nxt = col_q + 1'b1;
        if (col_q == hb_q - 1'b1) begin
          state_nxt = ACTIVE;
          col_nxt   = '0;
        end
      end
      ACTIVE: begin
        addr_nxt = addr_q + 1'b1;
        col_nxt  = col_q + 1'b1;
        if (col_q == aip_q - 1'b1) begin
          if (row_q == ail_q - 1'b1) begin
            addr_nxt  = '0;
            row_nxt   = '0;
            state_nxt = IDLE;
            if (enable) begin
              if (cfg_ok) go_frame = 1'b1;
              else        err_nxt  = 1'b1;
            end
          end else begin
            row_nxt = row_q + 1'b1;
            go_act  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (go_frame) begin
      hb_nxt   = HBOut_PD;
      vb_nxt   = VBOut_PD;
      aip_nxt  = AIPOut_PD;
      ail_nxt  = AILOut_PD;
      addr_nxt = '0;
      row_nxt  = '0;
      go_vb    = (VBOut_PD != '0);
      go_act   = (VBOut_PD == '0);
    end
    // hb_nxt is the freshly latched HB on a frame start, otherwise the running value.
    if (go_vb) begin
      state_nxt  = VBLANK;
      col_nxt    = '0;
      vseg_nxt   = (hb_nxt == '0);
      lstart_nxt = 1'b1;
    end
    if (go_act) begin
      state_nxt  = (hb_nxt == '0) ? ACTIVE : HBLANK;
      col_nxt    = '0;
      lstart_nxt = 1'b1;
    end
  end

  assign frame_rd_en   = (state == ACTIVE);
  assign frame_rd_addr = addr_q;
  assign pix_valid     = pv_q;
  assign pix_data      = pv_q ? frame_rd_data : '0;
  assign hsync         = lstart_q;
  assign vsync         = (state == VBLANK);
  assign line_cnt      = (state == HBLANK || state == ACTIVE) ? row_q : '0;
  assign frame_done    = done_q;
  assign cfg_err       = err_q;

endmodule
